// File: rtl/attack_arbiter.sv
// Two-player strike arbiter. A round-robin winner goes through a fixed
// wind-up, a single strike cycle in which its range input is sampled, and a
// cooldown before the next request is taken. A hit lowers the defender's
// health, and the game halts once a health value reaches zero.
module attack_arbiter #(
    parameter int WINDUP   = 4,
    parameter int COOLDOWN = 8,
    parameter int DAMAGE   = 10,
    parameter int MAX_HP   = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1_attack,
    input  logic       p2_attack,
    input  logic       p1_hitrange,
    input  logic       p2_hitrange,
    output logic       grant_p1,
    output logic       grant_p2,
    output logic       busy,
    output logic       hit_p1,
    output logic       hit_p2,
    output logic [6:0] hp_p1,
    output logic [6:0] hp_p2,
    output logic       game_over
);

    // State names carry an ST_ prefix so they do not collide with the
    // WINDUP/COOLDOWN parameters.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WINDUP,
        ST_STRIKE,
        ST_COOLDOWN,
        ST_HALT
    } state_t;

    localparam logic [3:0] WINDUP_LOAD = 4'(WINDUP - 1);
    localparam logic [3:0] COOL_LOAD   = 4'(COOLDOWN - 1);
    localparam logic [6:0] DMG         = 7'(DAMAGE);
    localparam logic [6:0] HP_INIT     = 7'(MAX_HP);

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    // Winner of the current or most recent attack: 0 = player 1, 1 = player 2.
    // This same register also remembers who was granted last, which drives
    // the round-robin tie break.
    logic            winner_reg, winner_next;
    logic            game_over_reg, game_over_next;
    logic [1:0][6:0] hp_reg, hp_next;
    logic [1:0]      hit_reg, hit_next;
    logic [1:0]      grant_vec;

    logic            strike_land;
    logic            defender_zero;

    // The winner's range input only matters in the closing edge of STRIKE.
    assign strike_land = (state_reg == ST_STRIKE) &&
                         (winner_reg ? p2_hitrange : p1_hitrange);

    // Per-player health update, hit pulse and grant (index 0 = p1, 1 = p2).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_player
            localparam logic ME = 1'(gi);
            logic [6:0] hp_damaged;

            // Compare before subtracting so that health saturates at zero.
            assign hp_damaged    = (hp_reg[gi] <= DMG) ? 7'd0 : (hp_reg[gi] - DMG);
            assign hp_next[gi]   = (strike_land && (winner_reg != ME)) ? hp_damaged
                                                                       : hp_reg[gi];
            assign hit_next[gi]  = strike_land && (winner_reg == ME);
            assign grant_vec[gi] = ((state_reg == ST_WINDUP) || (state_reg == ST_STRIKE)) &&
                                   (winner_reg == ME);
        end
    endgenerate

    // Defender's post-strike health, used to decide between HALT and COOLDOWN.
    assign defender_zero = (winner_reg ? hp_next[0] : hp_next[1]) == 7'd0;

    // Next-state logic: arbitration, wind-up/cooldown countdown, end of game.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        winner_next    = winner_reg;
        game_over_next = game_over_reg;
        case (state_reg)
            ST_IDLE: begin
                if (p1_attack || p2_attack) begin
                    state_next  = ST_WINDUP;
                    cnt_next    = WINDUP_LOAD;
                    winner_next = (p1_attack && p2_attack) ? ~winner_reg : p2_attack;
                end
            end
            ST_WINDUP: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_STRIKE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_STRIKE: begin
                if (strike_land && defender_zero) begin
                    state_next     = ST_HALT;
                    game_over_next = 1'b1;
                end else begin
                    state_next = ST_COOLDOWN;
                    cnt_next   = COOL_LOAD;
                end
            end
            ST_COOLDOWN: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register. Reset wins over a strike in progress, so an aborted
    // attack leaves health untouched and produces no hit pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            winner_reg    <= 1'b1;
            game_over_reg <= 1'b0;
            hp_reg        <= {HP_INIT, HP_INIT};
            hit_reg       <= 2'b00;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            winner_reg    <= winner_next;
            game_over_reg <= game_over_next;
            hp_reg        <= hp_next;
            hit_reg       <= hit_next;
        end
    end

    assign grant_p1  = grant_vec[0];
    assign grant_p2  = grant_vec[1];
    assign busy      = (state_reg != ST_IDLE);
    assign hit_p1    = hit_reg[0];
    assign hit_p2    = hit_reg[1];
    assign hp_p1     = hp_reg[0];
    assign hp_p2     = hp_reg[1];
    assign game_over = game_over_reg;

endmodule

// File: doc/attack_arbiter.md
ATTACK_ARBITER -- requirements
Module: attack_arbiter

Interface
REQ-001 Parameter WINDUP, default 4, attack wind-up length in clk cycles (legal 1..15).
REQ-002 Parameter COOLDOWN, default 8, post-strike recovery length in clk cycles (legal 1..15).
REQ-003 Parameter DAMAGE, default 10, health removed per landed hit (legal 1..100).
REQ-004 Parameter MAX_HP, default 100, health loaded at reset (legal 1..127).
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-007 p1_attack, p2_attack  input  1 each  level attack requests from player 1 and player 2.
REQ-008 p1_hitrange, p2_hitrange  input  1 each  the opponent is within the named player's strike range (registered collision result).
REQ-009 grant_p1, grant_p2  output  1 each  the named player owns the strike resource; at most one is high.
REQ-010 busy  output  1  the FSM is not in IDLE.
REQ-011 hit_p1, hit_p2  output  1 each  one-cycle pulse: the named player landed a hit.
REQ-012 hp_p1, hp_p2  output  7 each  current health.
REQ-013 game_over  output  1  sticky; a health value has reached 0.

Function
REQ-014 FSM states SHALL be IDLE, WINDUP, STRIKE, COOLDOWN and HALT.
REQ-015 IDLE: if any request is high at an edge, go to WINDUP, latch the winner, and load the counter with WINDUP-1; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: a single requester wins; on simultaneous requests the player not granted last wins; last_winner resets to player 2, so player 1 wins the first tie.
REQ-017 Requests outside IDLE SHALL be ignored and not queued.
REQ-018 WINDUP: decrement the counter each cycle; when it is 0, go to STRIKE, so WINDUP lasts exactly WINDUP cycles.
REQ-019 STRIKE: lasts exactly 1 cycle, and the winner's hitrange input is sampled at its closing edge.
REQ-020 On a sampled hitrange of 1, the defender's hp SHALL decrease by DAMAGE, saturating at 0, and the winner's hit output SHALL pulse high for exactly the next cycle.
REQ-021 The grant of the winner SHALL be high during WINDUP and STRIKE only; busy SHALL be high in WINDUP, STRIKE, COOLDOWN and HALT.
REQ-022 After STRIKE, if the new defender hp is 0, go to HALT and set game_over at the same edge; otherwise go to COOLDOWN with the counter loaded with COOLDOWN-1.
REQ-023 COOLDOWN: decrement the counter; when it is 0, go to IDLE, so COOLDOWN lasts exactly COOLDOWN cycles.
REQ-024 HALT SHALL be absorbing until reset, with all grants low, requests ignored, and hp frozen.
REQ-025 Latency: a request sampled at edge 0 gives grant in cycles 1..WINDUP+1, a hit pulse in cycle WINDUP+2, IDLE in cycle WINDUP+COOLDOWN+2, and the earliest next grant in cycle WINDUP+COOLDOWN+3.
REQ-026 Hitrange changes during WINDUP or COOLDOWN SHALL have no effect; only the STRIKE-edge sample counts.
REQ-027 Health arithmetic SHALL use a compare-before-subtract: if hp <= DAMAGE, the result is 0; otherwise it is hp-DAMAGE; no wrap-around.

Reset
REQ-028 While reset=0 at an edge: state IDLE, counter 0, last_winner player 2, hp_p1=hp_p2=MAX_HP, game_over=0.
REQ-029 While reset=0 at an edge: grants, busy and hit outputs SHALL all be 0.
REQ-030 Reset asserted mid-attack, including in STRIKE, SHALL abort the attack with no hp change and no hit pulse.
REQ-031 Outputs SHALL be undefined-free from the first edge with reset=0.

Verification
REQ-032 Default parameters, p1_attack pulsed at edge 0, p1_hitrange=1 -> grant_p1 high cycles 1..5, hit_p1 high cycle 6 only, hp_p2 100->90, busy low from cycle 14.
REQ-033 Both requests held high continuously, both hitranges 1 -> grants alternate p1, p2, p1, ...; the first two hits leave hp_p2=90 and hp_p1=90.
REQ-034 p2 attacks with p2_hitrange=0 at the STRIKE edge but 1 during WINDUP -> no hit_p2 pulse and hp_p1 stays 100.
REQ-035 DAMAGE=30, p1 lands 4 hits -> hp_p2 goes 70, 40, 10, 0 (saturated); game_over=1; FSM in HALT; further requests produce no grant.
REQ-036 reset=0 applied in the STRIKE cycle with hitrange=1 -> no hit pulse, hp_p2=100, IDLE next cycle, and p1 wins the next tie.
REQ-037 p2_attack asserted during p1's COOLDOWN then dropped before IDLE -> no grant_p2 issued.
